// File: rtl/pay_ctrl.sv
// pay_ctrl: payment controller in front of the payment display stage.
// Define COIN_DEBOUNCE_EN to add a stability filter on each coin input.

module pay_edge #(
  parameter bit FILT_EN  = 1'b0,
  parameter int FILT_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic pulse_o
);

  logic s1_q, s2_q, lvl, prev_q, pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din_i;
      s2_q <= s1_q;
    end
  end

  generate
    if (FILT_EN && (FILT_CYC > 0)) begin : g_filt
      logic        filt_q;
      logic [31:0] cnt_q;

      // Level only follows the input once it has held for FILT_CYC cycles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          filt_q <= 1'b0;
          cnt_q  <= 32'(FILT_CYC - 1);
        end else if (s2_q == filt_q) begin
          cnt_q  <= 32'(FILT_CYC - 1);
        end else if (cnt_q == 32'd0) begin
          filt_q <= s2_q;
          cnt_q  <= 32'(FILT_CYC - 1);
        end else begin
          cnt_q  <= cnt_q - 32'd1;
        end
      end

      assign lvl = filt_q;
    end else begin : g_raw
      assign lvl = s2_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= lvl;
      pulse_q <= lvl & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// state   | meaning
// IDLE    | waiting for start; digit outputs hold last transaction
// PAYING  | accumulating coins, display enabled, timeout running
// SUCCESS | paid >= cost, change shown for RESULT_S seconds
// REFUND  | cancelled or timed out, paid amount shown as refund
module pay_ctrl #(
  parameter int CLK_HZ    = 100000000,
  parameter int TIMEOUT_S = 30,
  parameter int RESULT_S  = 3,
  parameter int DEB_MS    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cancel,
  input  logic       coin1,
  input  logic       coin5,
  input  logic       coin10,
  input  logic [3:0] costone_in,
  input  logic [3:0] costten_in,
  output logic [3:0] costone,
  output logic [3:0] costten,
  output logic [3:0] paidone,
  output logic [3:0] paidten,
  output logic       pay_en_n,
  output logic [3:0] changeone,
  output logic [3:0] changeten,
  output logic       done,
  output logic       refund,
  output logic       timed_out
);

  typedef enum logic [1:0] {IDLE, PAYING, SUCCESS, REFUND} state_t;

  localparam int CYC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SEC_MAX = (TIMEOUT_S > RESULT_S) ? TIMEOUT_S : RESULT_S;
  localparam int SEC_W   = (SEC_MAX > 0) ? $clog2(SEC_MAX + 1) : 1;
  localparam longint DEB_CYC_L = longint'(DEB_MS) * longint'(CLK_HZ) / 1000;
  localparam int DEB_CYC = int'(DEB_CYC_L);

`ifdef COIN_DEBOUNCE_EN
  localparam bit COIN_FILT_EN = 1'b1;
`else
  localparam bit COIN_FILT_EN = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [7:0]         cost_q, cost_d;
  logic [7:0]         paid_q, paid_d, paid_nx;
  logic [7:0]         change_q, change_d;
  logic               to_q, to_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic               start_p, cancel_p, c1_p, c5_p, c10_p;
  logic [7:0]         coin_val;

  pay_edge #(.FILT_EN(1'b0), .FILT_CYC(1)) u_start (
    .clk(clk), .rst(rst), .din_i(start), .pulse_o(start_p));
  pay_edge #(.FILT_EN(1'b0), .FILT_CYC(1)) u_cancel (
    .clk(clk), .rst(rst), .din_i(cancel), .pulse_o(cancel_p));
  pay_edge #(.FILT_EN(COIN_FILT_EN), .FILT_CYC(DEB_CYC)) u_coin1 (
    .clk(clk), .rst(rst), .din_i(coin1), .pulse_o(c1_p));
  pay_edge #(.FILT_EN(COIN_FILT_EN), .FILT_CYC(DEB_CYC)) u_coin5 (
    .clk(clk), .rst(rst), .din_i(coin5), .pulse_o(c5_p));
  pay_edge #(.FILT_EN(COIN_FILT_EN), .FILT_CYC(DEB_CYC)) u_coin10 (
    .clk(clk), .rst(rst), .din_i(coin10), .pulse_o(c10_p));

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [7:0] bcd_add_sat(input logic [7:0] a, input logic [7:0] b);
    logic [4:0] o, t;
    o = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    t = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    if (o > 5'd9) begin
      o = o - 5'd10;
      t = t + 5'd1;
    end
    if (t > 5'd9) return 8'h99;
    return {t[3:0], o[3:0]};
  endfunction

  function automatic logic bcd_ge(input logic [7:0] a, input logic [7:0] b);
    return (a[7:4] > b[7:4]) || ((a[7:4] == b[7:4]) && (a[3:0] >= b[3:0]));
  endfunction

  // Caller guarantees a >= b, so the tens digit never underflows.
  function automatic logic [7:0] bcd_sub(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] o, t;
    if (a[3:0] < b[3:0]) begin
      o = a[3:0] + 4'd10 - b[3:0];
      t = a[7:4] - b[7:4] - 4'd1;
    end else begin
      o = a[3:0] - b[3:0];
      t = a[7:4] - b[7:4];
    end
    return {t, o};
  endfunction

  assign coin_val = c10_p ? 8'h10 :
                    c5_p  ? 8'h05 :
                    c1_p  ? 8'h01 : 8'h00;

  always_comb begin
    state_d  = state_q;
    cost_d   = cost_q;
    paid_d   = paid_q;
    change_d = change_q;
    to_d     = to_q;
    paid_nx  = bcd_add_sat(paid_q, coin_val);
    if (cyc_q == CYC_W'(CLK_HZ - 1)) begin
      cyc_d = '0;
      sec_d = (sec_q == '1) ? sec_q : sec_q + SEC_W'(1);
    end else begin
      cyc_d = cyc_q + CYC_W'(1);
      sec_d = sec_q;
    end

    case (state_q)
      IDLE: begin
        cyc_d = '0;
        sec_d = '0;
        if (start_p) begin
          state_d  = PAYING;
          cost_d   = {bcd_clamp(costten_in), bcd_clamp(costone_in)};
          paid_d   = 8'h00;
          change_d = 8'h00;
          to_d     = 1'b0;
        end
      end
      PAYING: begin
        // Completion wins over cancel and timeout; the coin of a refund cycle still counts.
        if (bcd_ge(paid_q, cost_q)) begin
          state_d  = SUCCESS;
          change_d = bcd_sub(paid_q, cost_q);
        end else begin
          paid_d = paid_nx;
          if (cancel_p) begin
            state_d  = REFUND;
            change_d = paid_nx;
            to_d     = 1'b0;
          end else if (sec_q == SEC_W'(TIMEOUT_S)) begin
            state_d  = REFUND;
            change_d = paid_nx;
            to_d     = 1'b1;
          end
        end
      end
      default: begin
        if (sec_q == SEC_W'(RESULT_S)) begin
          state_d = IDLE;
          to_d    = 1'b0;
        end
      end
    endcase

    if (state_d != state_q) begin
      cyc_d = '0;
      sec_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cost_q   <= 8'h00;
      paid_q   <= 8'h00;
      change_q <= 8'h00;
      to_q     <= 1'b0;
      cyc_q    <= '0;
      sec_q    <= '0;
    end else begin
      state_q  <= state_d;
      cost_q   <= cost_d;
      paid_q   <= paid_d;
      change_q <= change_d;
      to_q     <= to_d;
      cyc_q    <= cyc_d;
      sec_q    <= sec_d;
    end
  end

  assign costten   = cost_q[7:4];
  assign costone   = cost_q[3:0];
  assign paidten   = paid_q[7:4];
  assign paidone   = paid_q[3:0];
  assign changeten = change_q[7:4];
  assign changeone = change_q[3:0];
  assign pay_en_n  = (state_q != PAYING);
  assign done      = (state_q == SUCCESS);
  assign refund    = (state_q == REFUND);
  assign timed_out = (state_q == REFUND) && to_q;

endmodule
